// File: rtl/copperv_bus_arbiter_if.sv
// rtl/copperv_bus_arbiter_if.sv - Wishbone classic single-transfer bus bundle
interface copperv_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH/8-1:0] sel;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic                    ack;
  logic                    err;

  modport master (output cyc, stb, we, adr, dat_w, sel, input dat_r, ack, err);
  modport slave  (input cyc, stb, we, adr, dat_w, sel, output dat_r, ack, err);
  // memory side carries no error line
  modport mem_master (output cyc, stb, we, adr, dat_w, sel, input dat_r, ack);
  modport mem_slave  (input cyc, stb, we, adr, dat_w, sel, output dat_r, ack);
endinterface

// File: rtl/copperv_bus_arbiter.sv
// rtl/copperv_bus_arbiter.sv - two-master Wishbone arbiter with watchdog; ARB_ROUND_ROBIN_EN selects round-robin
module copperv_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  copperv_bus_arbiter_if.slave      inst,
  copperv_bus_arbiter_if.slave      data,
  copperv_bus_arbiter_if.mem_master mem,
  output logic [1:0]                grant
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    OWN_INST = 2'b01,
    OWN_DATA = 2'b10
  } state_t;

  state_t                state;
  logic                  last_data;
  logic [CNT_WIDTH-1:0]  wd_cnt;

  logic                  inst_req;
  logic                  data_req;
  logic                  pick_data;
  logic                  timeout;
  logic                  own_cyc;
  logic                  own_stb;
  logic                  own_we;
  logic [ADDR_WIDTH-1:0] own_adr;
  logic [DATA_WIDTH-1:0] own_dat_w;
  logic [SEL_WIDTH-1:0]  own_sel;

  assign inst_req = inst.cyc && inst.stb;
  assign data_req = data.cyc && data.stb;

`ifdef ARB_ROUND_ROBIN_EN
  assign pick_data = data_req && (!inst_req || !last_data);
`else
  assign pick_data = data_req;
`endif

  // Raw compare, deliberately not qualified by mem_ack so mem_cyc never depends on ack
  assign timeout = WD_EN && (state != IDLE) && (wd_cnt == CNT_LIMIT);

  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    own_we    = 1'b0;
    own_adr   = '0;
    own_dat_w = '0;
    own_sel   = '0;
    case (state)
      OWN_INST: begin
        own_cyc   = inst.cyc;
        own_stb   = inst.cyc && inst.stb;
        own_we    = inst.we;
        own_adr   = inst.adr;
        own_dat_w = inst.dat_w;
        own_sel   = inst.sel;
      end
      OWN_DATA: begin
        own_cyc   = data.cyc;
        own_stb   = data.cyc && data.stb;
        own_we    = data.we;
        own_adr   = data.adr;
        own_dat_w = data.dat_w;
        own_sel   = data.sel;
      end
      default: ;
    endcase
  end

  assign mem.cyc   = own_cyc && !timeout;
  assign mem.stb   = own_stb && !timeout;
  assign mem.we    = own_we;
  assign mem.adr   = own_adr;
  assign mem.dat_w = own_dat_w;
  assign mem.sel   = own_sel;

  assign inst.dat_r = mem.dat_r;
  assign data.dat_r = mem.dat_r;
  assign inst.ack   = (state == OWN_INST) && mem.ack;
  assign data.ack   = (state == OWN_DATA) && mem.ack;
  assign inst.err   = (state == OWN_INST) && timeout && !mem.ack;
  assign data.err   = (state == OWN_DATA) && timeout && !mem.ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= 2'b00;
      wd_cnt    <= '0;
      last_data <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (inst_req || data_req) begin
            if (pick_data) begin
              state     <= OWN_DATA;
              grant     <= 2'b10;
              last_data <= 1'b1;
            end else begin
              state     <= OWN_INST;
              grant     <= 2'b01;
              last_data <= 1'b0;
            end
          end
        end
        OWN_INST, OWN_DATA: begin
          if (mem.ack || !own_cyc || timeout) begin
            state <= IDLE;
            grant <= 2'b00;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_copperv_bus_arbiter.sv
// tb/tb_copperv_bus_arbiter.sv - directed bench for copperv_bus_arbiter (watchdog set to 4 cycles)
module tb_copperv_bus_arbiter;
  logic       clk;
  logic       rst;
  logic [1:0] grant;
  int         n_cmp;
  int         n_bad;

  copperv_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) inst_bus ();
  copperv_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) data_bus ();
  copperv_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_bus ();

  copperv_bus_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .inst (inst_bus),
    .data (data_bus),
    .mem  (mem_bus),
    .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_inst(input logic req, input logic [31:0] adr);
    inst_bus.cyc   = req;
    inst_bus.stb   = req;
    inst_bus.we    = 1'b0;
    inst_bus.adr   = adr;
    inst_bus.dat_w = 32'h0;
    inst_bus.sel   = 4'hF;
  endtask

  task automatic drive_data(input logic req, input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
    data_bus.cyc   = req;
    data_bus.stb   = req;
    data_bus.we    = we;
    data_bus.adr   = adr;
    data_bus.dat_w = dat;
    data_bus.sel   = sel;
  endtask

  task automatic drive_mem(input logic ack, input logic [31:0] dat);
    mem_bus.ack   = ack;
    mem_bus.dat_r = dat;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_inst(1'b0, 32'h0);
    drive_data(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_mem(1'b0, 32'h1234_5678);
    mem_bus.err = 1'b0;
    #2;
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b want 00", grant); end
    n_cmp++; if (mem_bus.cyc !== 1'b0 || mem_bus.stb !== 1'b0) begin n_bad++; $display("FAIL reset_mem_cyc: got cyc=%b stb=%b want 0 0", mem_bus.cyc, mem_bus.stb); end
    n_cmp++; if (inst_bus.ack !== 1'b0 || data_bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_ack_err: got ack=%b err=%b want 0 0", inst_bus.ack, data_bus.err); end
    n_cmp++; if (inst_bus.dat_r !== 32'h1234_5678 || data_bus.dat_r !== 32'h1234_5678) begin n_bad++; $display("FAIL reset_dat_r: got %h/%h want 12345678", inst_bus.dat_r, data_bus.dat_r); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_inst_read();
    drive_inst(1'b1, 32'h100);
    settle();
    n_cmp++; if (mem_bus.cyc !== 1'b0 || grant !== 2'b00) begin n_bad++; $display("FAIL single_first_cycle: got cyc=%b grant=%b want 0 00", mem_bus.cyc, grant); end
    tick();
    n_cmp++; if (grant !== 2'b01 || mem_bus.cyc !== 1'b1 || mem_bus.adr !== 32'h100) begin n_bad++; $display("FAIL single_grant: got grant=%b cyc=%b adr=%h want 01 1 100", grant, mem_bus.cyc, mem_bus.adr); end
    n_cmp++; if (inst_bus.ack !== 1'b0) begin n_bad++; $display("FAIL single_early_ack: got %b want 0", inst_bus.ack); end
    tick();
    n_cmp++; if (grant !== 2'b01 || mem_bus.cyc !== 1'b1) begin n_bad++; $display("FAIL single_wait: got grant=%b cyc=%b want 01 1", grant, mem_bus.cyc); end
    tick();
    drive_mem(1'b1, 32'hDEAD_BEEF);
    settle();
    n_cmp++; if (inst_bus.ack !== 1'b1 || inst_bus.dat_r !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL single_ack: got ack=%b dat=%h want 1 deadbeef", inst_bus.ack, inst_bus.dat_r); end
    n_cmp++; if (data_bus.ack !== 1'b0) begin n_bad++; $display("FAIL single_data_ack: got %b want 0", data_bus.ack); end
    tick();
    drive_inst(1'b0, 32'h0);
    drive_mem(1'b0, 32'h0);
    settle();
    n_cmp++; if (grant !== 2'b00 || inst_bus.ack !== 1'b0 || mem_bus.cyc !== 1'b0) begin n_bad++; $display("FAIL single_release: got grant=%b ack=%b cyc=%b want 00 0 0", grant, inst_bus.ack, mem_bus.cyc); end
  endtask

  task automatic test_simultaneous();
    logic [1:0]  exp_g;
    logic [31:0] exp_a;
    drive_inst(1'b1, 32'h0);
    drive_data(1'b1, 1'b1, 32'h200, 32'hCAFE_0001, 4'b0011);
    settle();
    n_cmp++; if (mem_bus.cyc !== 1'b0) begin n_bad++; $display("FAIL sim_not_forwarded: got cyc=%b want 0", mem_bus.cyc); end
    tick();
    drive_mem(1'b1, 32'h0);
    settle();
    n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("FAIL sim_first_owner: got %b want 10", grant); end
    n_cmp++; if (mem_bus.adr !== 32'h200 || mem_bus.we !== 1'b1 || mem_bus.sel !== 4'b0011 || mem_bus.dat_w !== 32'hCAFE_0001) begin n_bad++; $display("FAIL sim_data_route: got adr=%h we=%b sel=%b dat=%h want 200 1 0011 cafe0001", mem_bus.adr, mem_bus.we, mem_bus.sel, mem_bus.dat_w); end
    n_cmp++; if (data_bus.ack !== 1'b1 || inst_bus.ack !== 1'b0) begin n_bad++; $display("FAIL sim_ack_route: got data=%b inst=%b want 1 0", data_bus.ack, inst_bus.ack); end
    tick();
    drive_data(1'b1, 1'b0, 32'h204, 32'h0, 4'hF);
    drive_mem(1'b0, 32'h0);
    settle();
    n_cmp++; if (grant !== 2'b00 || mem_bus.cyc !== 1'b0) begin n_bad++; $display("FAIL sim_idle_gap: got grant=%b cyc=%b want 00 0", grant, mem_bus.cyc); end
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = 2'b01; exp_a = 32'h0;
`else
    exp_g = 2'b10; exp_a = 32'h204;
`endif
    drive_mem(1'b1, 32'h5555_AAAA);
    settle();
    n_cmp++; if (grant !== exp_g || mem_bus.adr !== exp_a) begin n_bad++; $display("FAIL sim_second_owner: got grant=%b adr=%h want %b %h", grant, mem_bus.adr, exp_g, exp_a); end
    tick();
    if (exp_g == 2'b01) drive_inst(1'b0, 32'h0);
    else drive_data(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_mem(1'b0, 32'h0);
    tick();
    exp_g = ~exp_g;
    exp_a = (exp_g == 2'b01) ? 32'h0 : 32'h204;
    drive_mem(1'b1, 32'h0);
    settle();
    n_cmp++; if (grant !== exp_g || mem_bus.adr !== exp_a) begin n_bad++; $display("FAIL sim_third_owner: got grant=%b adr=%h want %b %h", grant, mem_bus.adr, exp_g, exp_a); end
    tick();
    drive_inst(1'b0, 32'h0);
    drive_data(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_mem(1'b0, 32'h0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic       exp_last_data;
    logic [1:0] exp_g;
    int         inst_cnt;
    int         data_cnt;
    exp_last_data = 1'b1;
    inst_cnt = 0;
    data_cnt = 0;
    drive_inst(1'b1, 32'h40);
    drive_data(1'b1, 1'b0, 32'h80, 32'h0, 4'hF);
    drive_mem(1'b1, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = exp_last_data ? 2'b01 : 2'b10;
`else
      exp_g = 2'b10;
`endif
      exp_last_data = (exp_g == 2'b10);
      n_cmp++; if (grant !== exp_g) begin n_bad++; $display("FAIL b2b_grant_%0d: got %b want %b", i, grant, exp_g); end
      if (grant == 2'b01) inst_cnt++;
      if (grant == 2'b10) data_cnt++;
      tick();
      n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL b2b_idle_%0d: got %b want 00", i, grant); end
    end
`ifdef ARB_ROUND_ROBIN_EN
    n_cmp++; if (inst_cnt !== 4 || data_cnt !== 4) begin n_bad++; $display("FAIL b2b_share: got inst=%0d data=%0d want 4 4", inst_cnt, data_cnt); end
`else
    n_cmp++; if (inst_cnt !== 0 || data_cnt !== 8) begin n_bad++; $display("FAIL b2b_share: got inst=%0d data=%0d want 0 8", inst_cnt, data_cnt); end
`endif
    drive_inst(1'b0, 32'h0);
    drive_data(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_mem(1'b0, 32'h0);
    tick();
  endtask

  task automatic test_timeout();
    drive_data(1'b1, 1'b1, 32'h300, 32'h1111_2222, 4'hF);
    tick();
    drive_inst(1'b1, 32'h500);
    settle();
    n_cmp++; if (grant !== 2'b10 || mem_bus.cyc !== 1'b1 || data_bus.err !== 1'b0) begin n_bad++; $display("FAIL tmo_grant: got grant=%b cyc=%b err=%b want 10 1 0", grant, mem_bus.cyc, data_bus.err); end
    for (int i = 1; i < 4; i++) begin
      tick();
      n_cmp++; if (data_bus.err !== 1'b0 || mem_bus.cyc !== 1'b1) begin n_bad++; $display("FAIL tmo_wait_%0d: got err=%b cyc=%b want 0 1", i, data_bus.err, mem_bus.cyc); end
    end
    tick();
    n_cmp++; if (data_bus.err !== 1'b1 || mem_bus.cyc !== 1'b0 || mem_bus.stb !== 1'b0) begin n_bad++; $display("FAIL tmo_fire: got err=%b cyc=%b stb=%b want 1 0 0", data_bus.err, mem_bus.cyc, mem_bus.stb); end
    n_cmp++; if (inst_bus.err !== 1'b0 || data_bus.ack !== 1'b0 || grant !== 2'b10) begin n_bad++; $display("FAIL tmo_side: got inst_err=%b ack=%b grant=%b want 0 0 10", inst_bus.err, data_bus.ack, grant); end
    tick();
    drive_data(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    settle();
    n_cmp++; if (grant !== 2'b00 || data_bus.err !== 1'b0) begin n_bad++; $display("FAIL tmo_release: got grant=%b err=%b want 00 0", grant, data_bus.err); end
    tick();
    drive_mem(1'b1, 32'h0);
    settle();
    n_cmp++; if (grant !== 2'b01 || mem_bus.adr !== 32'h500 || inst_bus.ack !== 1'b1) begin n_bad++; $display("FAIL tmo_pending_inst: got grant=%b adr=%h ack=%b want 01 500 1", grant, mem_bus.adr, inst_bus.ack); end
    tick();
    drive_inst(1'b0, 32'h0);
    drive_mem(1'b0, 32'h0);
    tick();
  endtask

  task automatic test_abort();
    drive_inst(1'b1, 32'h600);
    tick();
    n_cmp++; if (grant !== 2'b01 || mem_bus.cyc !== 1'b1) begin n_bad++; $display("FAIL abort_grant: got grant=%b cyc=%b want 01 1", grant, mem_bus.cyc); end
    tick();
    inst_bus.cyc = 1'b0;
    settle();
    n_cmp++; if (mem_bus.cyc !== 1'b0 || mem_bus.stb !== 1'b0) begin n_bad++; $display("FAIL abort_drop: got cyc=%b stb=%b want 0 0", mem_bus.cyc, mem_bus.stb); end
    n_cmp++; if (inst_bus.ack !== 1'b0 || inst_bus.err !== 1'b0) begin n_bad++; $display("FAIL abort_no_resp: got ack=%b err=%b want 0 0", inst_bus.ack, inst_bus.err); end
    tick();
    n_cmp++; if (grant !== 2'b00 || inst_bus.err !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got grant=%b err=%b want 00 0", grant, inst_bus.err); end
    inst_bus.stb = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_transfer();
    drive_data(1'b1, 1'b1, 32'h700, 32'h7777_0000, 4'hF);
    tick();
    n_cmp++; if (grant !== 2'b10 || mem_bus.cyc !== 1'b1) begin n_bad++; $display("FAIL rstmid_grant: got grant=%b cyc=%b want 10 1", grant, mem_bus.cyc); end
    #3;
    rst = 1'b0;
    #1;
    n_cmp++; if (mem_bus.cyc !== 1'b0 || mem_bus.stb !== 1'b0 || mem_bus.we !== 1'b0 || mem_bus.adr !== 32'h0) begin n_bad++; $display("FAIL rstmid_mem: got cyc=%b stb=%b we=%b adr=%h want 0 0 0 0", mem_bus.cyc, mem_bus.stb, mem_bus.we, mem_bus.adr); end
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL rstmid_grant0: got %b want 00", grant); end
    #1;
    rst = 1'b1;
    tick();
    drive_mem(1'b1, 32'h0);
    settle();
    n_cmp++; if (grant !== 2'b10 || mem_bus.cyc !== 1'b1 || data_bus.ack !== 1'b1) begin n_bad++; $display("FAIL rstmid_regrant: got grant=%b cyc=%b ack=%b want 10 1 1", grant, mem_bus.cyc, data_bus.ack); end
    tick();
    drive_data(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_mem(1'b0, 32'h0);
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single_inst_read();
    test_simultaneous();
    test_back_to_back();
    test_timeout();
    test_abort();
    test_reset_mid_transfer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
